// File: rtl/lc3b_types.sv
// Shared encodings for the LC-3b pipeline hazard logic: forwarding select
// values and pipeline stage indices.
package lc3b_types;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } lc3b_fwd_sel;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/hazard_unit_fwd_compare.sv
// Operand bypass selector for one EX source: the younger EX/MEM producer wins
// over MEM/WB, and an invalid stage never supplies a value.
module fwd_compare
    import lc3b_types::*;
#(
    parameter int REGW = 3
) (
    input  logic [REGW-1:0] ex_src_i,
    input  logic            ex_use_i,
    input  logic            v_ex_mem_i,
    input  logic            mem_ld_reg_i,
    input  logic [REGW-1:0] mem_dest_i,
    input  logic            v_mem_wb_i,
    input  logic            wb_ld_reg_i,
    input  logic [REGW-1:0] wb_dest_i,
    output lc3b_fwd_sel     sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_use_i && v_ex_mem_i && mem_ld_reg_i && (mem_dest_i == ex_src_i))
            sel_o = FWD_EXMEM;
        else if (ex_use_i && v_mem_wb_i && wb_ld_reg_i && (wb_dest_i == ex_src_i))
            sel_o = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_unit.sv
// LC-3b 5-stage pipeline hazard unit: stalls, bubbles, redirect flush, bypass
// selects and memory-stall watchdog. HAZARD_FORWARDING_EN enables bypassing.
module hazard_unit
    import lc3b_types::*;
#(
    parameter int REGW = 3,
    parameter int TOW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_mem_resp,
    input  logic            d_mem_req,
    input  logic            d_mem_resp,
    input  logic            redirect,
    input  logic [REGW-1:0] id_src_a,
    input  logic [REGW-1:0] id_src_b,
    input  logic            id_use_a,
    input  logic            id_use_b,
    input  logic [REGW-1:0] ex_src_a,
    input  logic [REGW-1:0] ex_src_b,
    input  logic            ex_use_a,
    input  logic            ex_use_b,
    input  logic [REGW-1:0] ex_dest,
    input  logic [REGW-1:0] mem_dest,
    input  logic [REGW-1:0] wb_dest,
    input  logic            ex_ld_reg,
    input  logic            mem_ld_reg,
    input  logic            wb_ld_reg,
    input  logic            ex_is_load,
    output logic            load_pc,
    output logic            load_if_id,
    output logic            load_id_ex,
    output logic            load_ex_mem,
    output logic            load_mem_wb,
    output logic            v_if_id,
    output logic            v_id_ex,
    output logic            v_ex_mem,
    output logic            v_mem_wb,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_timeout
);

    localparam logic [TOW-1:0] CNT_MAX = '1;

    logic [STG_WB:STG_ID] v_q, v_d;
    logic [TOW-1:0]       cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 dmiss, imiss, stall_id;

    assign dmiss = d_mem_req & ~d_mem_resp;
    assign imiss = ~i_mem_resp;

`ifdef HAZARD_FORWARDING_EN
    lc3b_fwd_sel sel_a, sel_b;

    fwd_compare #(.REGW(REGW)) u_fwd_a (
        .ex_src_i(ex_src_a), .ex_use_i(ex_use_a),
        .v_ex_mem_i(v_q[STG_MEM]), .mem_ld_reg_i(mem_ld_reg), .mem_dest_i(mem_dest),
        .v_mem_wb_i(v_q[STG_WB]), .wb_ld_reg_i(wb_ld_reg), .wb_dest_i(wb_dest),
        .sel_o(sel_a)
    );

    fwd_compare #(.REGW(REGW)) u_fwd_b (
        .ex_src_i(ex_src_b), .ex_use_i(ex_use_b),
        .v_ex_mem_i(v_q[STG_MEM]), .mem_ld_reg_i(mem_ld_reg), .mem_dest_i(mem_dest),
        .v_mem_wb_i(v_q[STG_WB]), .wb_ld_reg_i(wb_ld_reg), .wb_dest_i(wb_dest),
        .sel_o(sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    // Only a load in EX cannot be bypassed in time; everything else forwards.
    assign stall_id = v_q[STG_EX] & ex_is_load & ex_ld_reg &
                      ((id_use_a & (ex_dest == id_src_a)) |
                       (id_use_b & (ex_dest == id_src_b)));
`else
    logic wr_ex, wr_mem, wr_wb, hit_a, hit_b;
    logic unused_nofwd;

    assign wr_ex  = v_q[STG_EX]  & ex_ld_reg;
    assign wr_mem = v_q[STG_MEM] & mem_ld_reg;
    assign wr_wb  = v_q[STG_WB]  & wb_ld_reg;

    // Without bypassing, ID waits until every older writer has left MEM/WB.
    assign hit_a = id_use_a & ((wr_ex  & (ex_dest  == id_src_a)) |
                               (wr_mem & (mem_dest == id_src_a)) |
                               (wr_wb  & (wb_dest  == id_src_a)));
    assign hit_b = id_use_b & ((wr_ex  & (ex_dest  == id_src_b)) |
                               (wr_mem & (mem_dest == id_src_b)) |
                               (wr_wb  & (wb_dest  == id_src_b)));

    assign stall_id     = hit_a | hit_b;
    assign fwd_a        = FWD_RF;
    assign fwd_b        = FWD_RF;
    assign unused_nofwd = ^{ex_src_a, ex_src_b, ex_use_a, ex_use_b, ex_is_load};
`endif

    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        v_d[STG_ID]  = 1'b1;
        v_d[STG_EX]  = v_q[STG_ID];
        v_d[STG_MEM] = v_q[STG_EX];
        v_d[STG_WB]  = v_q[STG_MEM];
        if (dmiss) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            v_d         = v_q;
            v_d[STG_WB] = 1'b0;
        end else if (redirect) begin
            // The redirecting instruction itself continues into MEM/WB.
            v_d[STG_ID]  = 1'b0;
            v_d[STG_EX]  = 1'b0;
            v_d[STG_MEM] = 1'b0;
        end else if (stall_id) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            v_d[STG_ID] = v_q[STG_ID];
            v_d[STG_EX] = 1'b0;
        end else if (imiss) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            v_d[STG_ID] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (imiss || dmiss)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_d = timeout_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q       <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign v_if_id     = v_q[STG_ID];
    assign v_id_ex     = v_q[STG_EX];
    assign v_ex_mem    = v_q[STG_MEM];
    assign v_mem_wb    = v_q[STG_WB];
    assign mem_timeout = timeout_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REGW, default 3, register-index width.
REQ-002 SHALL have parameter TOW, default 8, memory-stall watchdog counter width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high, with ports named as follows.
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- i_mem_resp  in  1  instruction fetch complete this cycle
- d_mem_req  in  1  MEM stage read or write pending (already qualified by EX/MEM valid)
- d_mem_resp  in  1  data access complete this cycle
- redirect  in  1  MEM stage taken branch/JMP/JSR/TRAP (qualified by EX/MEM valid)
- id_src_a, id_src_b  in  REGW  ID-stage source registers
- id_use_a, id_use_b  in  1  ID instruction reads that source
- ex_src_a, ex_src_b  in  REGW  ID/EX-held source registers
- ex_use_a, ex_use_b  in  1  EX instruction reads that source
- ex_dest, mem_dest, wb_dest  in  REGW  destinations held in ID/EX, EX/MEM, MEM/WB
- ex_ld_reg, mem_ld_reg, wb_ld_reg  in  1  that stage writes the regfile
- ex_is_load  in  1  ID/EX holds LDR/LDB/LDI
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  pipe register enables
- v_if_id, v_id_ex, v_ex_mem, v_mem_wb  out  1  stage valid bits
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB wb value
- mem_timeout  out  1  sticky watchdog error

Function
REQ-004 SHALL compute dmiss = d_mem_req & !d_mem_resp; while high, hold PC, IF/ID, ID/EX and EX/MEM, and load MEM/WB with valid 0.
REQ-005 SHALL compute imiss = !i_mem_resp; while high and not dmiss, hold PC and IF/ID, advance the rest, and load IF/ID valid 0 only if ID advances.
REQ-006 SHALL detect load-use when v_id_ex & ex_is_load & ex_ld_reg and ex_dest matches a used id_src; SHALL hold PC and IF/ID and load ID/EX valid 0 (one bubble).
REQ-007 SHALL apply redirect only when not dmiss: load PC and clear v_if_id, v_id_ex and v_ex_mem at the edge (3 bubbles). Redirect overrides imiss and load-use.
REQ-008 SHALL propagate each valid bit with its pipe register; a held stage keeps its valid bit.
REQ-009 SHALL set the forwarding select to 01 when v_ex_mem & mem_ld_reg & mem_dest==ex_src & ex_use; else to 10 when v_mem_wb & wb_ld_reg & wb_dest==ex_src & ex_use; else to 00. EX/MEM has priority.
REQ-010 SHALL never forward or detect a hazard against an invalid stage.
REQ-011 SHALL count consecutive cycles with imiss|dmiss, clear the count on any cycle without them, and saturate at 2^TOW-1; on reaching saturation SHALL set mem_timeout until reset.
REQ-012 SHALL derive all load_* and fwd_* outputs combinationally from the current state and inputs; valid bits, counter and mem_timeout SHALL be registers.

Reset
REQ-013 SHALL clear all valid bits, the stall counter and mem_timeout asynchronously on reset; while reset is high, fwd_a/fwd_b=00 and load_* follow the valid-0 state.
REQ-014 SHALL discard any in-flight miss or redirect when reset asserts mid-operation; the first fetch after deassertion is a normal fetch.

Configuration
REQ-015 SHALL honour HAZARD_FORWARDING_EN. When defined: forwarding per REQ-009, and only load-use stalls ID. When undefined: fwd_a/fwd_b tied to 00, and any used ID source matching a valid writing dest in ID/EX, EX/MEM or MEM/WB stalls ID as in REQ-006.

Structure
REQ-016 SHALL place the fwd select encoding (lc3b_fwd_sel enum) and stage-index constants in lc3b_types.
REQ-017 SHALL implement the REQ-009 comparators in one sub-module, fwd_compare, instantiated once per operand.

Verification
REQ-018 ADD R1 followed by ADD R2,R1,R1 -> with forwarding: fwd_a=fwd_b=01 in the second instruction's EX cycle, no stall; without forwarding: 3 ID stall cycles.
REQ-019 LDR R3 followed by ADD R4,R3,#1 -> exactly one bubble (v_id_ex=0 one cycle), then fwd_a=10.
REQ-020 Taken BR reaching MEM -> load_pc=1 and v_if_id, v_id_ex, v_ex_mem all 0 the next cycle.
REQ-021 d_mem_resp held low 4 cycles during LDR -> PC/IF/ID/ID/EX/EX/MEM held 4 cycles, v_mem_wb=0 for those cycles, no instruction lost.
REQ-022 TOW=4, i_mem_resp low 15 cycles -> mem_timeout rises on the 15th stall cycle and stays high until reset pulse.
